// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: push side (In*) from fetch, pop side (Out*) toward decode.
interface if_id_queue_if;
  logic        InValid;
  logic [31:0] InPC;
  logic [31:0] InInstr;
  logic        InReady;
  logic        OutValid;
  logic [31:0] OutPC;
  logic [31:0] OutInstr;
  logic        OutReady;

  modport master (
    output InValid, InPC, InInstr, OutReady,
    input  InReady, OutValid, OutPC, OutInstr
  );

  modport slave (
    input  InValid, InPC, InInstr, OutReady,
    output InReady, OutValid, OutPC, OutInstr
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of {PC, instruction} pairs with flush and
// an empty-while-ready bubble counter. No bypass, no push-through when full.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  if_id_queue_if.slave             q,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [31:0]              BubbleCnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          bubble;
  logic          empty;

  assign empty      = (Count == '0);
  assign q.InReady  = (Count != FULL_CNT);
  assign q.OutValid = !empty;
  assign q.OutPC    = empty ? 32'h0 : pc_mem[rd_ptr];
  assign q.OutInstr = empty ? 32'h0 : instr_mem[rd_ptr];

  assign push   = q.InValid  && q.InReady  && !Flush;
  assign pop    = q.OutValid && q.OutReady && !Flush;
  assign bubble = q.OutReady && empty      && !Flush;

  // Control state: occupancy, pointers and the bubble counter (Flush leaves the counter alone)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      BubbleCnt <= '0;
    end else begin
      if (Flush) begin
        Count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      Count <= Count + 1'b1;
        else if (pop && !push) Count <= Count - 1'b1;
      end
      if (bubble) BubbleCnt <= BubbleCnt + 32'd1;
    end
  end

  // Entry storage: only Reset scrubs contents; Flush merely drops validity
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= q.InPC;
      instr_mem[wr_ptr] <= q.InInstr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        Flush;
  logic [2:0]  Count;
  logic [31:0] BubbleCnt;

  if_id_queue_if bus ();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .q         (bus.slave),
    .Count     (Count),
    .BubbleCnt (BubbleCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    Reset        = rst;
    Flush        = fl;
    bus.InValid  = iv;
    bus.InPC     = pc;
    bus.InInstr  = ins;
    bus.OutReady = ordy;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] pc, ins;
    logic        ordy;
    logic [2:0]  cnt;
    logic        rdy, vld;
    logic [31:0] opc, oins, bub;
  } vec_t;

  vec_t tbl [14];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] mbub;

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    //            rst   fl    iv    pc            ins           ordy  cnt   rdy   vld   opc           oins          bub
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 3'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h3000,     32'h34010001, 1'b0, 3'd1, 1'b1, 1'b1, 32'h3000,     32'h34010001, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h3004,     32'h34020002, 1'b0, 3'd2, 1'b1, 1'b1, 32'h3000,     32'h34010001, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h3008,     32'h00221821, 1'b0, 3'd3, 1'b1, 1'b1, 32'h3000,     32'h34010001, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h300C,     32'h1000FFFF, 1'b0, 3'd4, 1'b0, 1'b1, 32'h3000,     32'h34010001, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h3010,     32'hDEADBEEF, 1'b0, 3'd4, 1'b0, 1'b1, 32'h3000,     32'h34010001, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 3'd3, 1'b1, 1'b1, 32'h3004,     32'h34020002, 32'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 3'd2, 1'b1, 1'b1, 32'h3008,     32'h00221821, 32'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 3'd1, 1'b1, 1'b1, 32'h300C,     32'h1000FFFF, 32'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 3'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 3'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h3000,     32'h34010001, 1'b0, 3'd1, 1'b1, 1'b1, 32'h3000,     32'h34010001, 32'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h3000,     32'h34010001, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h5000,     32'h11111111, 1'b0, 3'd1, 1'b1, 1'b1, 32'h5000,     32'h11111111, 32'd0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy);
      step();
      check($sformatf("vec%0d Count", i),     32'(Count),        32'(tbl[i].cnt));
      check($sformatf("vec%0d InReady", i),   32'(bus.InReady),  32'(tbl[i].rdy));
      check($sformatf("vec%0d OutValid", i),  32'(bus.OutValid), 32'(tbl[i].vld));
      check($sformatf("vec%0d OutPC", i),     bus.OutPC,         tbl[i].opc);
      check($sformatf("vec%0d OutInstr", i),  bus.OutInstr,      tbl[i].oins);
      check($sformatf("vec%0d BubbleCnt", i), BubbleCnt,         tbl[i].bub);
    end

    // Streaming push+pop: head lags the pushed PC by one edge and pointers wrap
    do_reset();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b1);
      step();
      check($sformatf("stream%0d Count", i), 32'(Count), 32'd1);
      check($sformatf("stream%0d OutPC", i), bus.OutPC,  32'h3000 + 32'(4 * i));
      check($sformatf("stream%0d OutInstr", i), bus.OutInstr, 32'hA0000000 + 32'(i));
    end

    // Flush with concurrent push and pop from Count = 3, then no-bypass push
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h3100 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
      step();
    end
    check("flush_pre Count", 32'(Count), 32'd3);
    drive(1'b0, 1'b1, 1'b1, 32'h3200, 32'hBB, 1'b1);
    step();
    check("flush Count",    32'(Count),        32'd0);
    check("flush OutValid", 32'(bus.OutValid), 32'd0);
    check("flush OutPC",    bus.OutPC,         32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h4000, 32'hCAFE0000, 1'b0);
    #1;
    check("nobypass OutValid", 32'(bus.OutValid), 32'd0);
    check("nobypass OutPC",    bus.OutPC,         32'h0);
    step();
    bus.InValid = 1'b0;
    check("after_flush OutPC",    bus.OutPC,    32'h4000);
    check("after_flush OutInstr", bus.OutInstr, 32'hCAFE0000);

    // Bubble counter survives Flush, cleared by Reset
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check("bubble5", BubbleCnt, 32'd5);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    check("bubble_flush", BubbleCnt, 32'd5);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("bubble_reset", BubbleCnt, 32'd0);
    check("reset InReady", 32'(bus.InReady), 32'd1);
    Reset = 1'b0;

    // Randomized run against the queue model
    do_reset();
    mq.delete();
    mbub = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        r_rst, r_fl, r_iv, r_or;
      logic [31:0] r_pc, r_ins;
      ent_t        e;
      int          sz;
      r_rst = ($urandom_range(63) == 0);
      r_fl  = ($urandom_range(15) == 0);
      r_iv  = ($urandom_range(3) != 0);
      r_or  = ($urandom_range(1) == 1);
      r_pc  = $urandom;
      r_ins = $urandom;
      drive(r_rst, r_fl, r_iv, r_pc, r_ins, r_or);
      sz = mq.size();
      check("rnd Count",    32'(Count),        32'(sz));
      check("rnd InReady",  32'(bus.InReady),  32'(sz < DEPTH));
      check("rnd OutValid", 32'(bus.OutValid), 32'(sz != 0));
      check("rnd OutPC",    bus.OutPC,         (sz != 0) ? mq[0].pc  : 32'h0);
      check("rnd OutInstr", bus.OutInstr,      (sz != 0) ? mq[0].ins : 32'h0);
      check("rnd BubbleCnt", BubbleCnt,        mbub);
      step();
      if (r_rst) begin
        mq.delete();
        mbub = 32'd0;
      end else begin
        if (r_or && sz == 0 && !r_fl) mbub = mbub + 32'd1;
        if (r_fl) begin
          mq.delete();
        end else begin
          if (r_or && sz > 0) void'(mq.pop_front());
          if (r_iv && sz < DEPTH) begin
            e.pc  = r_pc;
            e.ins = r_ins;
            mq.push_back(e);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
